// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// A round-robin grant in IDLE accepts one operation. EXEC drives the ALU for
// EXEC_CYCLES cycles and then captures the result. RESP holds the result on a
// shared bus until the owning requester consumes it.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic [3:0]  req_ctrl_0,
    input  logic [3:0]  req_ctrl_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic [2:0]  alu_flags
);

    // EXEC_CYCLES is at most 4, so the countdown never exceeds 3.
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [3:0]         r_ctrl;
    logic               r_id;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_data;
    logic [2:0]         r_flags;
    logic               r_err;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic               w_rsp_hs;
    logic               w_illegal;

    // Grant: a lone valid requester wins; on a tie, the requester that was not served last wins.
    assign w_gnt0    = req_valid_0 & (~req_valid_1 | r_last_grant);
    assign w_gnt1    = req_valid_1 & (~req_valid_0 | ~r_last_grant);
    assign w_accept  = (r_state == IDLE) & (w_gnt0 | w_gnt1);
    assign w_rsp_hs  = (r_state == RESP) & (r_id ? rsp_ready_1 : rsp_ready_0);
    // Op codes 4'b1011 and up are reserved; they still go through EXEC but report an error.
    assign w_illegal = (r_ctrl >= 4'b1011);

    // The ALU sees the operands only while an operation is executing.
    assign alu_a     = (r_state == EXEC) ? r_a    : '0;
    assign alu_b     = (r_state == EXEC) ? r_b    : '0;
    assign alu_ctrl  = (r_state == EXEC) ? r_ctrl : '0;

    assign rsp_data  = r_data;
    assign rsp_flags = r_flags;
    assign rsp_err   = r_err;

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_0 = w_gnt0;
                req_ready_1 = w_gnt1;
                if (w_accept) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_0 = ~r_id;
                rsp_valid_1 = r_id;
                if (w_rsp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, EXEC countdown, and result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_ctrl       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_data       <= '0;
            r_flags      <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_a          <= w_gnt1 ? req_a_1    : req_a_0;
            r_b          <= w_gnt1 ? req_b_1    : req_b_0;
            r_ctrl       <= w_gnt1 ? req_ctrl_1 : req_ctrl_0;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_cnt        <= CNT_W'(EXEC_CYCLES - 1);
        end else if (r_state == EXEC) begin
            if (r_cnt == '0) begin
                r_data  <= w_illegal ? 32'd0 : alu_out;
                r_flags <= w_illegal ? 3'd0  : alu_flags;
                r_err   <= w_illegal;
            end else begin
                r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. It uses a behavioural ALU, a vector table for single
// transactions, and directed sequences for arbitration, back-pressure and reset.
// A second instance with EXEC_CYCLES=3 covers the longer latency.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [3:0]  req_ctrl_0, req_ctrl_1;
    logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_flags;

    logic        d3_req_valid_0, d3_req_ready_0, d3_req_ready_1;
    logic [31:0] d3_req_a_0, d3_req_b_0;
    logic [3:0]  d3_req_ctrl_0;
    logic        d3_rsp_valid_0, d3_rsp_valid_1, d3_rsp_ready_0;
    logic [31:0] d3_rsp_data;
    logic [2:0]  d3_rsp_flags;
    logic        d3_rsp_err;
    logic [31:0] d3_alu_a, d3_alu_b, d3_alu_out;
    logic [3:0]  d3_alu_ctrl;
    logic [2:0]  d3_alu_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] exp_data;
        logic [2:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    // Behavioural ALU: flags are {eq, ltu, lt}; codes without an operation below yield 0.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = a << b[4:0];
            4'b0110: r = a >> b[4:0];
            4'b1000: r = {31'd0, $signed(a) < $signed(b)};
            4'b1001: r = {31'd0, a < b};
            default: r = 32'd0;
        endcase
        return {r, a == b, a < b, $signed(a) < $signed(b)};
    endfunction

    always_comb {alu_out, alu_flags}       = alu_model(alu_a, alu_b, alu_ctrl);
    always_comb {d3_alu_out, d3_alu_flags} = alu_model(d3_alu_a, d3_alu_b, d3_alu_ctrl);

    alu_arbiter #(.EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    alu_arbiter #(.EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(d3_req_valid_0), .req_valid_1(1'b0),
        .req_ready_0(d3_req_ready_0), .req_ready_1(d3_req_ready_1),
        .req_a_0(d3_req_a_0), .req_b_0(d3_req_b_0), .req_a_1(32'd0), .req_b_1(32'd0),
        .req_ctrl_0(d3_req_ctrl_0), .req_ctrl_1(4'd0),
        .rsp_valid_0(d3_rsp_valid_0), .rsp_valid_1(d3_rsp_valid_1),
        .rsp_ready_0(d3_rsp_ready_0), .rsp_ready_1(1'b0),
        .rsp_data(d3_rsp_data), .rsp_flags(d3_rsp_flags), .rsp_err(d3_rsp_err),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_ctrl(d3_alu_ctrl),
        .alu_out(d3_alu_out), .alu_flags(d3_alu_flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the response of requester id on the EXEC_CYCLES=1 instance.
    task automatic wait_rsp(input logic id, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? rsp_valid_1 : rsp_valid_0) && n < 20);
    endtask

    task automatic consume(input logic id, input string tag);
        if (id) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;
        @(negedge clk);
        chk({tag, " released"}, {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        if (v.id) begin
            req_valid_1 = 1'b1; req_a_1 = v.a; req_b_1 = v.b; req_ctrl_1 = v.ctrl;
        end else begin
            req_valid_0 = 1'b1; req_a_0 = v.a; req_b_0 = v.b; req_ctrl_0 = v.ctrl;
        end
        #1;
        n = 0;
        while (!(v.id ? req_ready_1 : req_ready_0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, " grant"}, {30'd0, req_ready_1, req_ready_0}, v.id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        wait_rsp(v.id, n);
        chk({tag, " latency"}, n, 32'd2);
        chk({tag, " valid"}, {30'd0, rsp_valid_1, rsp_valid_0}, v.id ? 32'd2 : 32'd1);
        chk({tag, " data"}, rsp_data, v.exp_data);
        chk({tag, " flags"}, {29'd0, rsp_flags}, {29'd0, v.exp_flags});
        chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        consume(v.id, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        vecs[0] = '{1'b0, 32'd5,          32'd3,    4'b0000, 32'd8,          3'b000, 1'b0};
        vecs[1] = '{1'b1, 32'd3,          32'd5,    4'b0001, 32'hFFFF_FFFE,  3'b011, 1'b0};
        vecs[2] = '{1'b1, 32'd3,          32'd5,    4'b1111, 32'd0,          3'b000, 1'b1};
        vecs[3] = '{1'b0, 32'd7,          32'd7,    4'b0010, 32'd7,          3'b100, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd1,    4'b1000, 32'd1,          3'b001, 1'b0};
        vecs[5] = '{1'b0, 32'h10,         32'h20,   4'b0100, 32'h30,         3'b011, 1'b0};
        vecs[6] = '{1'b1, 32'd1,          32'd1,    4'b1010, 32'd0,          3'b100, 1'b0};
        vecs[7] = '{1'b0, 32'd1,          32'd2,    4'b1011, 32'd0,          3'b000, 1'b1};

        rst_n = 1'b0;
        req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0;
        req_a_0 = 0; req_b_0 = 0; req_a_1 = 0; req_b_1 = 0; req_ctrl_0 = 0; req_ctrl_1 = 0;
        d3_req_valid_0 = 0; d3_req_a_0 = 0; d3_req_b_0 = 0; d3_req_ctrl_0 = 0; d3_rsp_ready_0 = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        chk("rst rsp_flags_err", {28'd0, rsp_flags, rsp_err}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b_ctrl", alu_b | {28'd0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;

        // Both valid right after reset: r0 first, then r1; back-pressure on r0.
        @(negedge clk);
        req_valid_0 = 1; req_a_0 = 32'd3; req_b_0 = 32'd5; req_ctrl_0 = 4'b0001;
        req_valid_1 = 1; req_a_1 = 32'd3; req_b_1 = 32'd5; req_ctrl_1 = 4'b1001;
        #1;
        chk("both first grant", {30'd0, req_ready_1, req_ready_0}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_0 = 0;
        @(negedge clk);
        chk("both exec alu_a", alu_a, 32'd3);
        chk("both exec alu_ctrl", {28'd0, alu_ctrl}, 32'd1);
        chk("both exec no ready1", {31'd0, req_ready_1}, 32'd0);
        @(negedge clk);
        chk("both r0 valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd1);
        chk("both r0 data", rsp_data, 32'hFFFF_FFFE);
        chk("both r0 flags", {29'd0, rsp_flags}, 32'd3);
        rsp_ready_1 = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold valid0", {31'd0, rsp_valid_0}, 32'd1);
            chk("hold data", rsp_data, 32'hFFFF_FFFE);
            chk("hold ready1", {31'd0, req_ready_1}, 32'd0);
        end
        rsp_ready_1 = 0;
        consume(1'b0, "both r0");
        chk("both second grant", {30'd0, req_ready_1, req_ready_0}, 32'd2);
        @(posedge clk);
        #1;
        req_valid_1 = 0;
        wait_rsp(1'b1, n);
        chk("both r1 latency", n, 32'd2);
        chk("both r1 data", rsp_data, 32'd1);
        chk("both r1 flags", {29'd0, rsp_flags}, 32'd3);
        consume(1'b1, "both r1");

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Round-robin after r0 was last served: r1 wins. Withdraw without a handshake.
        @(negedge clk);
        req_valid_0 = 1; req_valid_1 = 1;
        #1;
        chk("rr grant r1", {30'd0, req_ready_1, req_ready_0}, 32'd2);
        req_valid_0 = 0; req_valid_1 = 0;
        #1;
        chk("withdraw no ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);

        // Reset during EXEC discards the operation.
        run_txn(vecs[0], "pre_rst");
        @(negedge clk);
        req_valid_0 = 1; req_a_0 = 32'd9; req_b_0 = 32'd4; req_ctrl_0 = 4'b0000;
        @(posedge clk);
        #1;
        req_valid_0 = 0;
        @(negedge clk);
        chk("exec alu_a", alu_a, 32'd9);
        rst_n = 1'b0;
        #1;
        chk("mid rst alu_a", alu_a, 32'd0);
        chk("mid rst rsp_data", rsp_data, 32'd0);
        chk("mid rst rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid_0 || rsp_valid_1) seen++;
        end
        chk("no rsp after rst", seen, 32'd0);
        run_txn(vecs[5], "post_rst");

        // EXEC_CYCLES=3: shift left, response 4 cycles after accept.
        @(negedge clk);
        d3_req_valid_0 = 1; d3_req_a_0 = 32'hF0; d3_req_b_0 = 32'd4; d3_req_ctrl_0 = 4'b0101;
        #1;
        chk("e3 grant", {31'd0, d3_req_ready_0}, 32'd1);
        @(posedge clk);
        #1;
        d3_req_valid_0 = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d3_rsp_valid_0 && n < 20);
        chk("e3 latency", n, 32'd4);
        chk("e3 data", d3_rsp_data, 32'hF00);
        chk("e3 flags_err", {28'd0, d3_rsp_flags, d3_rsp_err}, 32'd0);
        d3_rsp_ready_0 = 1;
        @(posedge clk);
        #1;
        d3_rsp_ready_0 = 0;
        @(negedge clk);
        chk("e3 released", {31'd0, d3_rsp_valid_0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
